// File: rtl/layer_mixer.sv
// -----------------------------------------------------------------------------
// layer_mixer
//
// Final pixel stage between the layer generators and vga_bitchange.
// Four colour-index layers are merged by fixed priority
// (score > char > obstacle > level > BG_IDX). The winning index goes through
// a writable palette (CLUT) to produce RGB, which is blanked outside the
// visible area. The block also watches for char/obstacle overlap during each
// frame and reports at most one debounced collision event per frame. After a
// report, it ignores overlaps for COOL_FR frames.
//
// Ports
//   CLK           system clock
//   RESET         synchronous, active-high reset
//   pix_ce        pixel-rate clock enable; the pixel pipeline advances only on it
//   bright        visible-area flag for the current pixel
//   frame         one-CLK start-of-frame pulse, coincident with a pix_ce
//   score_pix     score layer index        (highest priority)
//   char_pix      duck layer index
//   obstacle_pix  obstacle layer index
//   level_pix     background/ground index  (lowest priority)
//   pal_we        palette write strobe (independent of pix_ce)
//   pal_addr      palette write address
//   pal_data      palette write data {R,G,B}
//   rgb           pixel colour, 0 when blanked (2 pix_ce ticks after input)
//   bright_o      bright delayed to line up with rgb
//   collision     one-CLK pulse per reported collision
//   hit_count     saturating count of reported collisions
// -----------------------------------------------------------------------------
module layer_mixer #(
    parameter int CIDXW   = 3,
    parameter int COLRW   = 12,
    parameter int BG_IDX  = 1,
    parameter int COOL_FR = 30
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             pix_ce,
    input  logic             bright,
    input  logic             frame,
    input  logic [CIDXW-1:0] score_pix,
    input  logic [CIDXW-1:0] char_pix,
    input  logic [CIDXW-1:0] obstacle_pix,
    input  logic [CIDXW-1:0] level_pix,
    input  logic             pal_we,
    input  logic [CIDXW-1:0] pal_addr,
    input  logic [COLRW-1:0] pal_data,
    output logic [COLRW-1:0] rgb,
    output logic             bright_o,
    output logic             collision,
    output logic [7:0]       hit_count
);

    localparam int PAL_N = 1 << CIDXW;
    // With COOL_FR=0 the cooldown is never entered. The counter is kept
    // 1 bit wide so that it is never zero-width.
    localparam int CW    = (COOL_FR > 0) ? $clog2(COOL_FR + 1) : 1;

    typedef enum logic [1:0] {
        ARMED,
        SEEN,
        COOL
    } coll_state_t;

    // Default palette contents. Entries beyond 7 exist only for CIDXW > 3
    // and come up black.
    function automatic logic [COLRW-1:0] pal_default(input int i);
        logic [11:0] c;
        case (i)
            0:       c = 12'h000;
            1:       c = 12'h8CF;
            2:       c = 12'hFFF;
            3:       c = 12'h000;
            4:       c = 12'hFA0;
            5:       c = 12'h0A0;
            6:       c = 12'hF00;
            7:       c = 12'h888;
            default: c = 12'h000;
        endcase
        return COLRW'(c);
    endfunction

    logic [COLRW-1:0] pal [PAL_N];
    logic [CIDXW-1:0] winner;
    logic [CIDXW-1:0] idx_q;
    logic             b_q;
    logic             ovl_q;
    coll_state_t      state;
    logic [CW-1:0]    cool;
    logic             frame_tick;
    logic             ovl_tick;
    logic             report;

    // Priority merge: the first non-transparent layer wins.
    // If every layer is transparent, the background index is used.
    always_comb begin
        winner = CIDXW'(BG_IDX);
        if (score_pix != '0)
            winner = score_pix;
        else if (char_pix != '0)
            winner = char_pix;
        else if (obstacle_pix != '0)
            winner = obstacle_pix;
        else if (level_pix != '0)
            winner = level_pix;
    end

    // Palette storage. Stage 2 reads with the current contents, so a write
    // to the same entry in the same cycle is seen from the next CLK.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < PAL_N; i++)
                pal[i] <= pal_default(i);
        end else if (pal_we) begin
            pal[pal_addr] <= pal_data;
        end
    end

    // Two-stage pixel pipeline. Stage 1 registers the winning index, the
    // visible flag and the overlap flag. Stage 2 looks up the colour and
    // blanks it. Both stages hold while pix_ce is low.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            idx_q    <= '0;
            b_q      <= 1'b0;
            ovl_q    <= 1'b0;
            rgb      <= '0;
            bright_o <= 1'b0;
        end else if (pix_ce) begin
            idx_q    <= winner;
            b_q      <= bright;
            ovl_q    <= bright && (char_pix != '0) && (obstacle_pix != '0);
            rgb      <= b_q ? pal[idx_q] : '0;
            bright_o <= b_q;
        end
    end

    assign frame_tick = pix_ce & frame;
    assign ovl_tick   = pix_ce & ovl_q;

    // An overlap that shows up in ovl_q at the frame pulse came from the
    // last pixel of the old frame. An armed detector therefore reports it
    // right away instead of carrying it into the new frame.
    assign report = frame_tick &&
                    ((state == SEEN) || ((state == ARMED) && ovl_tick));

    // Collision detector: ARMED waits for an overlap, SEEN waits for the
    // end of the frame to report it, and COOL skips overlaps until the
    // cooldown frames have passed.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= ARMED;
            cool      <= '0;
            collision <= 1'b0;
            hit_count <= '0;
        end else begin
            collision <= 1'b0;
            if (report) begin
                collision <= 1'b1;
                if (hit_count != 8'hFF)
                    hit_count <= hit_count + 8'd1;
                if (COOL_FR > 0) begin
                    state <= COOL;
                    cool  <= CW'(COOL_FR - 1);
                end else begin
                    state <= ARMED;
                end
            end else begin
                case (state)
                    ARMED: begin
                        if (ovl_tick)
                            state <= SEEN;
                    end
                    SEEN: begin
                        state <= SEEN;
                    end
                    COOL: begin
                        if (frame_tick) begin
                            if (cool == '0)
                                state <= ARMED;
                            else
                                cool <= cool - CW'(1);
                        end
                    end
                    default: begin
                        state <= ARMED;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_layer_mixer.sv
// -----------------------------------------------------------------------------
// tb_layer_mixer
//
// Bench for layer_mixer. Two instances share the same inputs:
//   dut_a uses a two-frame cooldown;
//   dut_b has no cooldown, which is used to drive hit_count into saturation.
// A frame-level reference model predicts every output on every cycle.
// Directed sequences pin known colours and collision counts to literal values.
// A randomized phase then exercises the blocks with random pixels,
// random palette writes and occasional resets.
// -----------------------------------------------------------------------------
module tb_layer_mixer;

    localparam int COOL_A = 2;
    localparam int COOL_B = 0;

    logic        CLK          = 1'b0;
    logic        RESET        = 1'b1;
    logic        pix_ce       = 1'b0;
    logic        bright       = 1'b0;
    logic        frame        = 1'b0;
    logic [2:0]  score_pix    = '0;
    logic [2:0]  char_pix     = '0;
    logic [2:0]  obstacle_pix = '0;
    logic [2:0]  level_pix    = '0;
    logic        pal_we       = 1'b0;
    logic [2:0]  pal_addr     = '0;
    logic [11:0] pal_data     = '0;

    logic [11:0] rgb_a, rgb_b;
    logic        bright_o_a, bright_o_b;
    logic        collision_a, collision_b;
    logic [7:0]  hit_count_a, hit_count_b;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    layer_mixer #(.CIDXW(3), .COLRW(12), .BG_IDX(1), .COOL_FR(COOL_A)) dut_a (
        .CLK(CLK), .RESET(RESET), .pix_ce(pix_ce), .bright(bright), .frame(frame),
        .score_pix(score_pix), .char_pix(char_pix), .obstacle_pix(obstacle_pix),
        .level_pix(level_pix), .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
        .rgb(rgb_a), .bright_o(bright_o_a), .collision(collision_a), .hit_count(hit_count_a)
    );

    layer_mixer #(.CIDXW(3), .COLRW(12), .BG_IDX(1), .COOL_FR(COOL_B)) dut_b (
        .CLK(CLK), .RESET(RESET), .pix_ce(pix_ce), .bright(bright), .frame(frame),
        .score_pix(score_pix), .char_pix(char_pix), .obstacle_pix(obstacle_pix),
        .level_pix(level_pix), .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
        .rgb(rgb_b), .bright_o(bright_o_b), .collision(collision_b), .hit_count(hit_count_b)
    );

    always #5 CLK = ~CLK;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        bit b;
        int idx;
        bit ovl;
    } pix_t;

    int   pal_def [8] = '{'h000, 'h8CF, 'hFFF, 'h000, 'hFA0, 'h0A0, 'hF00, 'h888};
    int   pal_m   [8];
    pix_t pipe_q  [$];
    int   exp_rgb;
    bit   exp_bo;
    int   cool_left [2];
    bit   pending   [2];
    bit   exp_col   [2];
    int   exp_hits  [2];

    function automatic int cool_cfg(input int k);
        return (k == 0) ? COOL_A : COOL_B;
    endfunction

    function automatic int pick(input int s, input int c, input int o, input int l);
        int layers [4];
        int result;
        bit found;
        layers = '{s, c, o, l};
        result = 1;
        found  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!found && layers[i] != 0) begin
                result = layers[i];
                found  = 1'b1;
            end
        end
        return result;
    endfunction

    // One pixel is in flight between the input and the output. Each pix_ce
    // tick takes the oldest pixel out of the queue and displays it.
    // cool_left < 0 means the detector is armed.
    always @(posedge CLK) begin
        if (RESET) begin
            pipe_q.delete();
            pipe_q.push_back('{b: 1'b0, idx: 0, ovl: 1'b0});
            pal_m   = pal_def;
            exp_rgb = 0;
            exp_bo  = 1'b0;
            for (int k = 0; k < 2; k++) begin
                cool_left[k] = -1;
                pending[k]   = 1'b0;
                exp_col[k]   = 1'b0;
                exp_hits[k]  = 0;
            end
        end else begin
            pix_t head;
            pix_t np;
            for (int k = 0; k < 2; k++)
                exp_col[k] = 1'b0;
            if (pix_ce) begin
                head    = pipe_q.pop_front();
                exp_rgb = head.b ? pal_m[head.idx] : 0;
                exp_bo  = head.b;
                for (int k = 0; k < 2; k++) begin
                    if (cool_left[k] >= 0) begin
                        if (frame)
                            cool_left[k] = cool_left[k] - 1;
                    end else begin
                        if (head.ovl)
                            pending[k] = 1'b1;
                        if (frame && pending[k]) begin
                            exp_col[k]   = 1'b1;
                            exp_hits[k]  = (exp_hits[k] < 255) ? exp_hits[k] + 1 : 255;
                            pending[k]   = 1'b0;
                            cool_left[k] = cool_cfg(k) - 1;
                        end
                    end
                end
                np.b   = bright;
                np.idx = pick(int'(score_pix), int'(char_pix), int'(obstacle_pix), int'(level_pix));
                np.ovl = bright && (char_pix != 0) && (obstacle_pix != 0);
                pipe_q.push_back(np);
            end
            if (pal_we)
                pal_m[pal_addr] = int'(pal_data);
        end
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (check_en) begin
            checkOutput("rgb_a",       int'(rgb_a),       exp_rgb);
            checkOutput("rgb_b",       int'(rgb_b),       exp_rgb);
            checkOutput("bright_o_a",  int'(bright_o_a),  int'(exp_bo));
            checkOutput("bright_o_b",  int'(bright_o_b),  int'(exp_bo));
            checkOutput("collision_a", int'(collision_a), int'(exp_col[0]));
            checkOutput("collision_b", int'(collision_b), int'(exp_col[1]));
            checkOutput("hit_count_a", int'(hit_count_a), exp_hits[0]);
            checkOutput("hit_count_b", int'(hit_count_b), exp_hits[1]);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic applyStimulus(input bit ce, input bit br, input bit fr,
                                 input int s, input int c, input int o, input int l);
        pix_ce       = ce;
        bright       = br;
        frame        = fr;
        score_pix    = 3'(s);
        char_pix     = 3'(c);
        obstacle_pix = 3'(o);
        level_pix    = 3'(l);
        @(posedge CLK);
        #1;
    endtask

    task automatic show(input int s, input int c, input int o, input int l);
        applyStimulus(1'b1, 1'b1, 1'b0, s, c, o, l);
        applyStimulus(1'b1, 1'b1, 1'b0, s, c, o, l);
    endtask

    task automatic run_frame(input bit ovl, input int len, output int col_a, output int hits_a);
        applyStimulus(1'b1, 1'b1, 1'b1, 0, 0, 0, 5);
        col_a  = int'(collision_a);
        hits_a = int'(hit_count_a);
        for (int p = 1; p < len; p++) begin
            if (ovl && p >= 2 && p <= 4)
                applyStimulus(1'b1, 1'b1, 1'b0, 0, 4, 6, 5);
            else
                applyStimulus(1'b1, 1'b1, 1'b0, 0, 0, 0, 5);
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        RESET = 1'b0;
    endtask

    initial begin
        int ca, ha;
        int px_cnt;

        do_reset();
        do_reset();
        check_en = 1'b1;
        checkOutput("reset_rgb",  int'(rgb_a),       0);
        checkOutput("reset_bo",   int'(bright_o_a),  0);
        checkOutput("reset_hits", int'(hit_count_a), 0);
        checkOutput("reset_col",  int'(collision_a), 0);

        // Background colour appears exactly two pix_ce ticks after the input.
        applyStimulus(1'b1, 1'b1, 1'b0, 0, 0, 0, 0);
        checkOutput("bg_latency1", int'(rgb_a), 'h000);
        applyStimulus(1'b1, 1'b1, 1'b0, 0, 0, 0, 0);
        checkOutput("bg_latency2", int'(rgb_a), 'h8CF);
        checkOutput("bg_model",    exp_rgb,     'h8CF);
        checkOutput("bg_bright_o", int'(bright_o_a), 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        checkOutput("blanked", int'(rgb_a), 'h000);

        // Priority chain.
        show(2, 4, 6, 5); checkOutput("prio_score", int'(rgb_a), 'hFFF);
        show(0, 4, 6, 5); checkOutput("prio_char",  int'(rgb_a), 'hFA0);
        show(0, 0, 6, 5); checkOutput("prio_obst",  int'(rgb_a), 'hF00);
        checkOutput("prio_obst_model", exp_rgb, 'hF00);
        show(0, 0, 0, 5); checkOutput("prio_level", int'(rgb_a), 'h0A0);

        // Clock-enable freeze.
        show(0, 4, 0, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 2, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 6, 6, 6, 6);
        checkOutput("freeze_rgb", int'(rgb_a),      'hFA0);
        checkOutput("freeze_bo",  int'(bright_o_a), 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 0, 0, 0, 5);
        checkOutput("resume_rgb1", int'(rgb_a), 'hFFF);
        applyStimulus(1'b1, 1'b1, 1'b0, 0, 0, 0, 5);
        checkOutput("resume_rgb2", int'(rgb_a), 'h0A0);

        // Palette write while char index 4 is on screen.
        show(0, 4, 0, 0);
        pal_we = 1'b1; pal_addr = 3'd4; pal_data = 12'h123;
        applyStimulus(1'b1, 1'b1, 1'b0, 0, 4, 0, 0);
        pal_we = 1'b0;
        checkOutput("palwr_old", int'(rgb_a), 'hFA0);
        applyStimulus(1'b1, 1'b1, 1'b0, 0, 4, 0, 0);
        checkOutput("palwr_new", int'(rgb_a), 'h123);
        show(0, 0, 0, 5); checkOutput("palwr_other", int'(rgb_a), 'h0A0);

        // Collision with a two-frame cooldown.
        do_reset();
        run_frame(1'b0, 8, ca, ha);
        run_frame(1'b1, 8, ca, ha); checkOutput("coll_N",   ca, 0);
        run_frame(1'b1, 8, ca, ha); checkOutput("coll_N1",  ca, 1);
        checkOutput("hits_N1", ha, 1);
        run_frame(1'b1, 8, ca, ha); checkOutput("coll_N2",  ca, 0);
        run_frame(1'b1, 8, ca, ha); checkOutput("coll_N3",  ca, 0);
        checkOutput("hits_N3", ha, 1);
        run_frame(1'b0, 8, ca, ha); checkOutput("coll_N4",  ca, 1);
        checkOutput("hits_N4", ha, 2);

        // Reset while an overlap is pending.
        do_reset();
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 1'b1, 1'b0, 0, 4, 6, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 0, 0, 0, 0);
        do_reset();
        run_frame(1'b0, 4, ca, ha);
        checkOutput("rst_seen_col",  ca, 0);
        checkOutput("rst_seen_hits", ha, 0);
        show(0, 4, 0, 0); checkOutput("rst_pal_default", int'(rgb_a), 'hFA0);

        // Saturation with no cooldown.
        do_reset();
        for (int f = 0; f < 262; f++)
            run_frame(1'b1, 4, ca, ha);
        checkOutput("sat_hits_b",  int'(hit_count_b), 255);
        checkOutput("sat_model_b", exp_hits[1],       255);

        // Randomized traffic.
        do_reset();
        px_cnt = 0;
        for (int n = 0; n < 4000; n++) begin
            bit ce, fr;
            ce = ($urandom_range(0, 3) != 0);
            fr = 1'b0;
            if (ce) begin
                fr = (px_cnt % 16 == 0);
                px_cnt++;
            end
            RESET    = ($urandom_range(0, 499) == 0);
            pal_we   = ($urandom_range(0, 19) == 0);
            pal_addr = 3'($urandom_range(0, 7));
            pal_data = 12'($urandom);
            applyStimulus(ce, ($urandom_range(0, 4) != 0), fr,
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0,
                          ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 7)) : 0,
                          ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 7)) : 0,
                          int'($urandom_range(0, 7)));
        end
        RESET  = 1'b0;
        pal_we = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
